// File: rtl/flush_recovery_ctrl.sv
// flush_recovery_ctrl: sequences branch-misprediction recovery.
// A CDB flush is held for DRAIN_CYCLES cycles, then a one-cycle restore
// strobe moves the FRL head and ROB bottom back, then one resume cycle.
// A flush from an older branch (smaller ROB depth) arriving mid-recovery
// restarts the sequence; a flush from a younger branch is dropped.
// Optional feature: define FLUSH_RECOVERY_STATS_EN to add Rcv_FlushCnt,
// a saturating count of accepted flushes.
`timescale 1ns/1ps

module flush_recovery_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Resetb,
    input  logic        Cdb_Flush,
    input  logic [4:0]  Cdb_RobTag,
    input  logic [4:0]  Cdb_RobDepth,
    input  logic [4:0]  Cfc_FrlHeadPtr,
    input  logic        Cfc_Full,
    input  logic        Dis_InstValid,
    input  logic        Dis_CfcBranch,
    input  logic        Dis_Jr31Inst,
    output logic        Rcv_DisStall,
    output logic        Rcv_Busy,
    output logic        Rcv_FrlRestore,
    output logic [4:0]  Rcv_FrlHeadPtr,
    output logic        Rcv_RobRestore,
`ifdef FLUSH_RECOVERY_STATS_EN
    output logic [15:0] Rcv_FlushCnt,
`endif
    output logic [4:0]  Rcv_RobTag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RESTORE = 2'd2,
        RESUME  = 2'd3
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] tag_q, tag_d;
    logic [4:0] depth_q, depth_d;
    logic [4:0] frl_q, frl_d;
    logic       accept;
    logic       restore;

    // State, drain counter and captured flush context.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            depth_q <= '0;
            frl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            depth_q <= depth_d;
            frl_q   <= frl_d;
        end
    end

    // Next-state logic: flush acceptance, drain countdown, restore strobe.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        depth_d = depth_q;
        frl_d   = frl_q;
        accept  = 1'b0;
        restore = 1'b0;

        // Mid-recovery, only a flush from an older branch (closer to the
        // ROB top) supersedes the one already captured.
        unique case (state_q)
            IDLE, RESUME:   accept = Cdb_Flush;
            DRAIN, RESTORE: accept = Cdb_Flush && (Cdb_RobDepth < depth_q);
            default:        accept = 1'b0;
        endcase

        unique case (state_q)
            IDLE: ;
            DRAIN: begin
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d   = '0;
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                restore = 1'b1;
                state_d = RESUME;
            end
            RESUME:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A newly accepted flush wins over everything, including a restore
        // that would otherwise fire this cycle with stale context.
        if (accept) begin
            tag_d   = Cdb_RobTag;
            depth_d = Cdb_RobDepth;
            frl_d   = Cfc_FrlHeadPtr;
            cnt_d   = CNT_LOAD;
            state_d = DRAIN;
            restore = 1'b0;
        end
    end

    assign Rcv_Busy       = (state_q != IDLE);
    assign Rcv_FrlRestore = restore;
    assign Rcv_RobRestore = restore;
    assign Rcv_FrlHeadPtr = frl_q;
    assign Rcv_RobTag     = tag_q;
    assign Rcv_DisStall   = Cdb_Flush || Rcv_Busy ||
                            (Cfc_Full && Dis_InstValid && (Dis_CfcBranch || Dis_Jr31Inst));

`ifdef FLUSH_RECOVERY_STATS_EN
    logic [15:0] flush_cnt_q;

    // Saturating count of accepted flushes; dropped flushes never count.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            flush_cnt_q <= '0;
        end else if (accept && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign Rcv_FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_flush_recovery_ctrl.sv
// Directed bench for flush_recovery_ctrl with DRAIN_CYCLES=2.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
`timescale 1ns/1ps

module tb_flush_recovery_ctrl;

    logic        Clk;
    logic        Resetb;
    logic        Cdb_Flush;
    logic [4:0]  Cdb_RobTag;
    logic [4:0]  Cdb_RobDepth;
    logic [4:0]  Cfc_FrlHeadPtr;
    logic        Cfc_Full;
    logic        Dis_InstValid;
    logic        Dis_CfcBranch;
    logic        Dis_Jr31Inst;
    logic        Rcv_DisStall;
    logic        Rcv_Busy;
    logic        Rcv_FrlRestore;
    logic [4:0]  Rcv_FrlHeadPtr;
    logic        Rcv_RobRestore;
    logic [4:0]  Rcv_RobTag;
`ifdef FLUSH_RECOVERY_STATS_EN
    logic [15:0] Rcv_FlushCnt;
`endif

    int checks = 0;
    int errors = 0;

    flush_recovery_ctrl #(.DRAIN_CYCLES(2)) dut (
        .Clk            (Clk),
        .Resetb         (Resetb),
        .Cdb_Flush      (Cdb_Flush),
        .Cdb_RobTag     (Cdb_RobTag),
        .Cdb_RobDepth   (Cdb_RobDepth),
        .Cfc_FrlHeadPtr (Cfc_FrlHeadPtr),
        .Cfc_Full       (Cfc_Full),
        .Dis_InstValid  (Dis_InstValid),
        .Dis_CfcBranch  (Dis_CfcBranch),
        .Dis_Jr31Inst   (Dis_Jr31Inst),
        .Rcv_DisStall   (Rcv_DisStall),
        .Rcv_Busy       (Rcv_Busy),
        .Rcv_FrlRestore (Rcv_FrlRestore),
        .Rcv_FrlHeadPtr (Rcv_FrlHeadPtr),
        .Rcv_RobRestore (Rcv_RobRestore),
`ifdef FLUSH_RECOVERY_STATS_EN
        .Rcv_FlushCnt   (Rcv_FlushCnt),
`endif
        .Rcv_RobTag     (Rcv_RobTag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Busy and both restore strobes for the current cycle.
    task automatic look(input string tag, input logic busy, input logic stb);
        #1;
        check({tag, "_busy"},    32'(Rcv_Busy),       32'(busy));
        check({tag, "_frl_rst"}, 32'(Rcv_FrlRestore), 32'(stb));
        check({tag, "_rob_rst"}, 32'(Rcv_RobRestore), 32'(stb));
    endtask

    // Advance to just after the next rising edge and drop any flush pulse.
    task automatic adv();
        @(posedge Clk);
        #1;
        Cdb_Flush = 1'b0;
    endtask

    task automatic flush(input logic [4:0] tag, input logic [4:0] depth, input logic [4:0] frl);
        Cdb_Flush      = 1'b1;
        Cdb_RobTag     = tag;
        Cdb_RobDepth   = depth;
        Cfc_FrlHeadPtr = frl;
    endtask

    task automatic do_reset(input string tag);
        Cdb_Flush = 1'b0;
        Resetb    = 1'b0;
        #1;
        check({tag, "_rst_busy"}, 32'(Rcv_Busy),   32'd0);
        check({tag, "_rst_tag"},  32'(Rcv_RobTag), 32'd0);
        Resetb = 1'b1;
        adv();
    endtask

    initial begin
        Resetb = 1'b0;
        Cdb_Flush = 1'b0;
        Cdb_RobTag = '0;
        Cdb_RobDepth = '0;
        Cfc_FrlHeadPtr = '0;
        Cfc_Full = 1'b0;
        Dis_InstValid = 1'b0;
        Dis_CfcBranch = 1'b0;
        Dis_Jr31Inst = 1'b0;

        // Reset state; stall still follows the flush input while in reset.
        #2;
        look("reset", 1'b0, 1'b0);
        check("reset_robtag", 32'(Rcv_RobTag),     32'd0);
        check("reset_frlptr", 32'(Rcv_FrlHeadPtr), 32'd0);
        check("reset_stall",  32'(Rcv_DisStall),   32'd0);
        Cdb_Flush = 1'b1;
        #1;
        check("reset_stall_flush", 32'(Rcv_DisStall), 32'd1);
        check("reset_busy_flush",  32'(Rcv_Busy),     32'd0);
        Cdb_Flush = 1'b0;
        #1;
        Resetb = 1'b1;
        adv();
`ifdef FLUSH_RECOVERY_STATS_EN
        check("reset_cnt", 32'(Rcv_FlushCnt), 32'd0);
`endif

        // Basic recovery: tag 9, depth 3, FRL 17.
        flush(5'd9, 5'd3, 5'd17);
        look("s1_c0", 1'b0, 1'b0);
        check("s1_c0_stall", 32'(Rcv_DisStall), 32'd1);
        adv();
        look("s1_c1", 1'b1, 1'b0);
        check("s1_c1_stall", 32'(Rcv_DisStall), 32'd1);
        adv();
        look("s1_c2", 1'b1, 1'b0);
        adv();
        look("s1_c3", 1'b1, 1'b1);
        check("s1_c3_robtag", 32'(Rcv_RobTag),     32'd9);
        check("s1_c3_frlptr", 32'(Rcv_FrlHeadPtr), 32'd17);
        check("s1_c3_stall",  32'(Rcv_DisStall),   32'd1);
        adv();
        look("s1_c4", 1'b1, 1'b0);
        check("s1_c4_stall", 32'(Rcv_DisStall), 32'd1);
        adv();
        look("s1_c5", 1'b0, 1'b0);
        check("s1_c5_stall",  32'(Rcv_DisStall), 32'd0);
        check("s1_c5_robtag", 32'(Rcv_RobTag),   32'd9);

        // Older flush during DRAIN restarts the drain.
        do_reset("s2");
        flush(5'd1, 5'd6, 5'd2);
        look("s2_c0", 1'b0, 1'b0);
        adv();
        look("s2_c1", 1'b1, 1'b0);
        adv();
        flush(5'd4, 5'd2, 5'd10);
        look("s2_c2", 1'b1, 1'b0);
        adv();
        look("s2_c3", 1'b1, 1'b0);
        adv();
        look("s2_c4", 1'b1, 1'b0);
        adv();
        look("s2_c5", 1'b1, 1'b1);
        check("s2_c5_robtag", 32'(Rcv_RobTag),     32'd4);
        check("s2_c5_frlptr", 32'(Rcv_FrlHeadPtr), 32'd10);
        adv();
        look("s2_c6", 1'b1, 1'b0);
        adv();
        look("s2_c7", 1'b0, 1'b0);

        // Older flush landing in the RESTORE cycle suppresses that strobe.
        do_reset("s3");
        flush(5'd3, 5'd6, 5'd8);
        adv();
        look("s3_c1", 1'b1, 1'b0);
        adv();
        look("s3_c2", 1'b1, 1'b0);
        adv();
        flush(5'd7, 5'd1, 5'd20);
        look("s3_c3", 1'b1, 1'b0);
        check("s3_c3_robtag", 32'(Rcv_RobTag), 32'd3);
        adv();
        look("s3_c4", 1'b1, 1'b0);
        adv();
        look("s3_c5", 1'b1, 1'b0);
        adv();
        look("s3_c6", 1'b1, 1'b1);
        check("s3_c6_robtag", 32'(Rcv_RobTag),     32'd7);
        check("s3_c6_frlptr", 32'(Rcv_FrlHeadPtr), 32'd20);
        adv();
        look("s3_c7", 1'b1, 1'b0);
        adv();
        look("s3_c8", 1'b0, 1'b0);

        // Younger and equal-depth flushes mid-recovery are dropped.
        do_reset("s4");
        flush(5'd11, 5'd2, 5'd13);
        adv();
        flush(5'd22, 5'd7, 5'd30);
        look("s4_c1", 1'b1, 1'b0);
        adv();
        flush(5'd23, 5'd2, 5'd31);
        look("s4_c2", 1'b1, 1'b0);
        adv();
        flush(5'd24, 5'd5, 5'd1);
        look("s4_c3", 1'b1, 1'b1);
        check("s4_c3_robtag", 32'(Rcv_RobTag),     32'd11);
        check("s4_c3_frlptr", 32'(Rcv_FrlHeadPtr), 32'd13);
        adv();
        look("s4_c4", 1'b1, 1'b0);
        check("s4_c4_robtag", 32'(Rcv_RobTag), 32'd11);
        adv();
        look("s4_c5", 1'b0, 1'b0);
`ifdef FLUSH_RECOVERY_STATS_EN
        check("s4_cnt", 32'(Rcv_FlushCnt), 32'd1);
`endif

        // Dispatch stall from checkpoint-table-full qualifiers in IDLE.
        do_reset("s5");
        Cfc_Full = 1'b1;
        Dis_InstValid = 1'b1;
        Dis_Jr31Inst = 1'b1;
        #1;
        check("s5_jr31_stall", 32'(Rcv_DisStall), 32'd1);
        check("s5_jr31_busy",  32'(Rcv_Busy),     32'd0);
        Dis_Jr31Inst = 1'b0;
        #1;
        check("s5_none_stall", 32'(Rcv_DisStall), 32'd0);
        Dis_CfcBranch = 1'b1;
        #1;
        check("s5_br_stall", 32'(Rcv_DisStall), 32'd1);
        Dis_InstValid = 1'b0;
        #1;
        check("s5_novalid_stall", 32'(Rcv_DisStall), 32'd0);
        Cfc_Full = 1'b0;
        Dis_CfcBranch = 1'b0;

        // Reset during DRAIN aborts with no restore afterwards.
        do_reset("s6");
        flush(5'd9, 5'd3, 5'd17);
        adv();
        look("s6_c1", 1'b1, 1'b0);
        Resetb = 1'b0;
        #1;
        check("s6_abort_busy",   32'(Rcv_Busy),       32'd0);
        check("s6_abort_frlrst", 32'(Rcv_FrlRestore), 32'd0);
        check("s6_abort_robtag", 32'(Rcv_RobTag),     32'd0);
        Resetb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adv();
            look("s6_after", 1'b0, 1'b0);
        end

        // Flush in RESUME starts a second recovery immediately.
        do_reset("s7");
        flush(5'd9, 5'd3, 5'd17);
        adv();
        look("s7_c1", 1'b1, 1'b0);
        adv();
        look("s7_c2", 1'b1, 1'b0);
        adv();
        look("s7_c3", 1'b1, 1'b1);
        adv();
        flush(5'd12, 5'd8, 5'd5);
        look("s7_c4", 1'b1, 1'b0);
        adv();
        look("s7_c5", 1'b1, 1'b0);
        adv();
        look("s7_c6", 1'b1, 1'b0);
        adv();
        look("s7_c7", 1'b1, 1'b1);
        check("s7_c7_robtag", 32'(Rcv_RobTag),     32'd12);
        check("s7_c7_frlptr", 32'(Rcv_FrlHeadPtr), 32'd5);
        adv();
        look("s7_c8", 1'b1, 1'b0);
        adv();
        look("s7_c9", 1'b0, 1'b0);
`ifdef FLUSH_RECOVERY_STATS_EN
        check("s7_cnt", 32'(Rcv_FlushCnt), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
